// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, FSM state type and select decode for the mux feeder
package rr_mux_pkg;
  localparam int N = 4;
  localparam int SEL_W = 2;
  localparam int W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
    return N'(1) << s;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searching last+1 .. last+4 (mod 4)
module rr_pick import rr_mux_pkg::*; (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  logic [SEL_W-1:0] c;
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = '0;
    // walk from farthest to nearest so the nearest requester after last wins
    for (int k = N; k >= 1; k--) begin
      c = last + SEL_W'(k);
      if (req[c]) begin
        idx = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder: holds one payload per channel and feeds a 4-way mux round-robin
module rr_mux_feeder import rr_mux_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   xfer_count
);
  state_t state, state_n;
  logic [N-1:0] slot_valid, load, req;
  logic [W-1:0] slot [N];
  logic [W-1:0] din [N];
  logic [SEL_W-1:0] last_grant, idx, last;
  logic found, hs;
  assign din[0] = in_data0;
  assign din[1] = in_data1;
  assign din[2] = in_data2;
  assign din[3] = in_data3;
  assign a = slot[0];
  assign b = slot[1];
  assign c = slot[2];
  assign d = slot[3];
  assign in_ready = ~slot_valid;
  assign load = in_valid & in_ready;
  assign hs = (state == GRANT) && out_ready;
  // while granting, the next pick excludes the slot being consumed and starts after it
  assign req = (state == GRANT) ? (slot_valid & ~onehot(sel)) : slot_valid;
  assign last = (state == GRANT) ? sel : last_grant;
  rr_pick u_pick (.req(req), .last(last), .idx(idx), .found(found));
  always_comb begin
    state_n = (state == IDLE) ? (found ? GRANT : IDLE) : ((out_ready && !found) ? IDLE : GRANT);
    out_valid = (state == GRANT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot <= '{default: '0};
      sel <= '0;
      last_grant <= 2'd3;
      xfer_count <= '0;
    end else begin
      slot_valid <= (slot_valid & ~(hs ? onehot(sel) : '0)) | load;
      for (int i = 0; i < N; i++) if (load[i]) slot[i] <= din[i];
      if (found && (state == IDLE || out_ready)) sel <= idx;
      if (hs) begin
        last_grant <= sel;
        xfer_count <= xfer_count + 8'd1;
      end
    end
  end
endmodule
